// File: rtl/spi_slave_pkg.sv
// rtl/spi_slave_pkg.sv - shared constants, status bit indices and bit-engine state type for spi_slave_port
package spi_slave_pkg;

    localparam logic [2:0] ADDR_RXDATA  = 3'd0;
    localparam logic [2:0] ADDR_TXDATA  = 3'd1;
    localparam logic [2:0] ADDR_STATUS  = 3'd2;
    localparam logic [2:0] ADDR_CONTROL = 3'd3;
    localparam logic [2:0] ADDR_EOPVAL  = 3'd6;

    localparam int ST_EOP  = 9;
    localparam int ST_E    = 8;
    localparam int ST_RRDY = 7;
    localparam int ST_TRDY = 6;
    localparam int ST_TMT  = 5;
    localparam int ST_TOE  = 4;
    localparam int ST_ROE  = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/spi_slave_sync.sv
// rtl/spi_slave_sync.sv - SCLK/SS_n/MOSI synchronisers with SCLK edge detection
module spi_slave_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sclk,
    input  logic ss_n,
    input  logic mosi,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic ss_act,
    output logic mosi_s
);

    // Slave select is synchronised inverted so that the all-zero reset state means "not selected".
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_d;
    logic                   sclk_s;

    // Shift the pins through the synchroniser chains and keep one SCLK history bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync <= '0;
            ss_sync   <= '0;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ~ss_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign ss_act    = ss_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave_port.sv
// rtl/spi_slave_port.sv - SPI mode-0 slave with register port; optional EOP detection via SPI_SLAVE_EOP_EN
module spi_slave_port
    import spi_slave_pkg::*;
#(
    parameter int DATABITS    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        SCLK,
    input  logic        SS_n,
    input  logic        MOSI,
    output logic        MISO,
    output logic        MISO_oe,
    input  logic        spi_select,
    input  logic [2:0]  mem_addr,
    input  logic        read_n,
    input  logic        write_n,
    input  logic [15:0] data_from_cpu,
    output logic [15:0] data_to_cpu,
    output logic        irq,
    output logic        dataavailable,
    output logic        readyfordata,
    output logic        endofpacket
);

    localparam int CW = $clog2(DATABITS);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATABITS - 1);
`ifdef SPI_SLAVE_EOP_EN
    localparam logic [15:0] CTRL_MASK = 16'h03D8;
`else
    localparam logic [15:0] CTRL_MASK = 16'h01D8;
`endif

    logic sclk_rise, sclk_fall, ss_act, mosi_s;

    spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .reset_n   (reset_n),
        .sclk      (SCLK),
        .ss_n      (SS_n),
        .mosi      (MOSI),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .ss_act    (ss_act),
        .mosi_s    (mosi_s)
    );

    state_t                state_q, state_d;
    logic [CW-1:0]         count;
    logic [DATABITS-1:0]   shift_reg, tx_holding, rx_holding, rx_byte;
    logic                  mosi_bit, primed, load, rx_done;
    logic                  rrdy, roe, toe, eop;
    logic [15:0]           ctrl_q, status_word, read_mux;
    logic                  acc_d, rd_acc, wr_acc;
    logic                  wr_tx, wr_status, wr_control, rd_rx, tx_accept;
    logic                  unused_bits;

    // Each access strobe is honoured for one clk; the cycle after an access is ignored.
    assign rd_acc     = spi_select & ~read_n & ~acc_d;
    assign wr_acc     = spi_select & ~write_n & ~acc_d;
    assign wr_tx      = wr_acc & (mem_addr == ADDR_TXDATA);
    assign wr_status  = wr_acc & (mem_addr == ADDR_STATUS);
    assign wr_control = wr_acc & (mem_addr == ADDR_CONTROL);
    assign rd_rx      = rd_acc & (mem_addr == ADDR_RXDATA);
    assign tx_accept  = wr_tx & ~primed;
    assign unused_bits = ^data_from_cpu[15:10];

    assign rx_byte = {shift_reg[DATABITS-2:0], mosi_s};
    assign rx_done = (state_q == SHIFT) & ss_act & sclk_rise & (count == LAST_BIT);

    // Bit-engine state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next state and byte-load strobe: load on select and after every complete byte.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (ss_act) begin
                    state_d = SHIFT;
                    load    = 1'b1;
                end
            end
            SHIFT: begin
                if (!ss_act)                               state_d = IDLE;
                else if (sclk_fall && count == LAST_BIT)   load    = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Shift register, bit counter, sampled MOSI and received byte.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_reg  <= '0;
            count      <= '0;
            mosi_bit   <= 1'b0;
            rx_holding <= '0;
        end else begin
            if (load) begin
                shift_reg <= primed ? tx_holding : '0;
                count     <= '0;
            end else if (state_q == SHIFT && ss_act && sclk_fall) begin
                shift_reg <= {shift_reg[DATABITS-2:0], mosi_bit};
                count     <= count + 1'b1;
            end else if (state_q == SHIFT && !ss_act) begin
                count     <= '0;
            end
            if (state_q == SHIFT && ss_act && sclk_rise) mosi_bit <= mosi_s;
            if (rx_done) rx_holding <= rx_byte;
        end
    end

    // TX holding register, status flags and control register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_holding <= '0;
            primed     <= 1'b0;
            toe        <= 1'b0;
            rrdy       <= 1'b0;
            roe        <= 1'b0;
            ctrl_q     <= '0;
            acc_d      <= 1'b0;
        end else begin
            acc_d <= rd_acc | wr_acc;
            if (tx_accept) begin
                tx_holding <= data_from_cpu[DATABITS-1:0];
                primed     <= 1'b1;
            end else if (load) begin
                primed     <= 1'b0;
            end
            if (wr_tx && primed)     toe <= 1'b1;
            else if (wr_status)      toe <= 1'b0;
            if (rx_done)                 rrdy <= 1'b1;
            else if (rd_rx || wr_status) rrdy <= 1'b0;
            if (rx_done && rrdy)     roe <= 1'b1;
            else if (wr_status)      roe <= 1'b0;
            if (wr_control)          ctrl_q <= data_from_cpu & CTRL_MASK;
        end
    end

`ifdef SPI_SLAVE_EOP_EN
    logic [15:0] eop_value;

    // End-of-packet match on received bytes and on bytes queued for transmit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            eop_value <= '0;
            eop       <= 1'b0;
        end else begin
            if (wr_acc && mem_addr == ADDR_EOPVAL) eop_value <= data_from_cpu;
            if ((rx_done && rx_byte == eop_value[DATABITS-1:0]) ||
                (wr_tx && data_from_cpu[DATABITS-1:0] == eop_value[DATABITS-1:0]))
                eop <= 1'b1;
            else if (wr_status)
                eop <= 1'b0;
        end
    end
`else
    assign eop = 1'b0;
`endif

    // Status word assembly and read-data selection.
    always_comb begin
        status_word          = '0;
        status_word[ST_EOP]  = eop;
        status_word[ST_E]    = roe | toe;
        status_word[ST_RRDY] = rrdy;
        status_word[ST_TRDY] = ~primed;
        status_word[ST_TMT]  = ~primed & (state_q != SHIFT);
        status_word[ST_TOE]  = toe;
        status_word[ST_ROE]  = roe;
        read_mux = '0;
        case (mem_addr)
            ADDR_RXDATA:  read_mux = {{(16-DATABITS){1'b0}}, rx_holding};
            ADDR_STATUS:  read_mux = status_word;
            ADDR_CONTROL: read_mux = ctrl_q;
`ifdef SPI_SLAVE_EOP_EN
            ADDR_EOPVAL:  read_mux = eop_value;
`endif
            default:      read_mux = '0;
        endcase
    end

    // Registered read data and interrupt.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_to_cpu <= '0;
            irq         <= 1'b0;
        end else begin
            if (rd_acc) data_to_cpu <= read_mux;
            irq <= |(status_word & ctrl_q);
        end
    end

    assign MISO          = shift_reg[DATABITS-1];
    assign MISO_oe       = ss_act;
    assign dataavailable = rrdy;
    assign readyfordata  = ~primed;
    assign endofpacket   = eop;

endmodule

// File: tb/tb_spi_slave_port.sv
// tb/tb_spi_slave_port.sv - directed self-checking bench for spi_slave_port
module tb_spi_slave_port;

    logic        clk = 1'b0;
    logic        reset_n, SCLK, SS_n, MOSI, MISO, MISO_oe;
    logic        spi_select, read_n, write_n, irq;
    logic        dataavailable, readyfordata, endofpacket;
    logic [2:0]  mem_addr;
    logic [15:0] data_from_cpu, data_to_cpu, rdata;
    logic [7:0]  mi;
    logic [15:0] ctrl_all_exp;
    int          n_asserts = 0;
    int          n_fail    = 0;

    always #5 clk = ~clk;

    spi_slave_port dut (
        .clk(clk), .reset_n(reset_n), .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI),
        .MISO(MISO), .MISO_oe(MISO_oe), .spi_select(spi_select), .mem_addr(mem_addr),
        .read_n(read_n), .write_n(write_n), .data_from_cpu(data_from_cpu),
        .data_to_cpu(data_to_cpu), .irq(irq), .dataavailable(dataavailable),
        .readyfordata(readyfordata), .endofpacket(endofpacket)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        spi_select = 1'b1; mem_addr = a; data_from_cpu = d; write_n = 1'b0;
        @(negedge clk);
        spi_select = 1'b0; write_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
        @(negedge clk);
        spi_select = 1'b1; mem_addr = a; read_n = 1'b0;
        @(negedge clk);
        spi_select = 1'b0; read_n = 1'b1;
        d = data_to_cpu;
        @(negedge clk);
    endtask

    task automatic ss_low();
        @(negedge clk); SS_n = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic ss_high();
        repeat (8) @(negedge clk);
        SS_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // Mode-0 master: drive MOSI while SCLK low, sample MISO at the rising edge.
    task automatic spi_xfer(input logic [7:0] mo, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            MOSI = mo[7-i];
            repeat (8) @(negedge clk);
            rx = {rx[6:0], MISO};
            SCLK = 1'b1;
            repeat (8) @(negedge clk);
            SCLK = 1'b0;
        end
    endtask

    initial begin
        reset_n = 1'b0; SCLK = 1'b0; SS_n = 1'b1; MOSI = 1'b0;
        spi_select = 1'b0; mem_addr = 3'd0; read_n = 1'b1; write_n = 1'b1;
        data_from_cpu = 16'h0000;
`ifdef SPI_SLAVE_EOP_EN
        ctrl_all_exp = 16'h03D8;
`else
        ctrl_all_exp = 16'h01D8;
`endif
        repeat (3) @(negedge clk);
        check("reset_miso_oe", {15'd0, MISO_oe}, 16'h0000);
        check("reset_irq", {15'd0, irq}, 16'h0000);
        check("reset_data_to_cpu", data_to_cpu, 16'h0000);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        bus_read(3'd2, rdata);  check("reset_status", rdata, 16'h0060);
        bus_read(3'd3, rdata);  check("reset_control", rdata, 16'h0000);
        check("reset_readyfordata", {15'd0, readyfordata}, 16'h0001);

        // Basic transfer: slave sends A5, master sends 3C.
        bus_write(3'd1, 16'h00A5);
        bus_read(3'd2, rdata);  check("primed_status", rdata, 16'h0000);
        ss_low();
        check("miso_oe_active", {15'd0, MISO_oe}, 16'h0001);
        spi_xfer(8'h3C, 8, mi);
        check("miso_byte_a5", {8'd0, mi}, 16'h00A5);
        ss_high();
        bus_read(3'd2, rdata);  check("rx_status", rdata, 16'h00E0);
        check("dataavailable", {15'd0, dataavailable}, 16'h0001);
        bus_read(3'd0, rdata);  check("rxdata_3c", rdata, 16'h003C);
        bus_read(3'd2, rdata);  check("rrdy_cleared", rdata, 16'h0060);

        // Control register masking and a TRDY interrupt.
        bus_write(3'd3, 16'hFFFF);
        bus_read(3'd3, rdata);  check("control_mask", rdata, ctrl_all_exp);
        check("irq_trdy", {15'd0, irq}, 16'h0001);
        bus_write(3'd3, 16'h0008);
        check("irq_off", {15'd0, irq}, 16'h0000);

        // Back-to-back bytes without reading: overrun.
        ss_low();
        spi_xfer(8'h81, 8, mi);
        spi_xfer(8'h7E, 8, mi);
        check("idle_tx_zero", {8'd0, mi}, 16'h0000);
        ss_high();
        bus_read(3'd2, rdata);  check("roe_status", rdata, 16'h01E8);
        check("irq_roe", {15'd0, irq}, 16'h0001);
        bus_read(3'd0, rdata);  check("rxdata_second", rdata, 16'h007E);
        bus_write(3'd2, 16'h0000);
        bus_read(3'd2, rdata);  check("status_clear", rdata, 16'h0060);
        check("irq_cleared", {15'd0, irq}, 16'h0000);
        bus_write(3'd3, 16'h0000);

        // Transmit overrun: second write is discarded.
        bus_write(3'd1, 16'h0011);
        bus_write(3'd1, 16'h0022);
        bus_read(3'd2, rdata);  check("toe_status", rdata, 16'h0110);
        ss_low();
        spi_xfer(8'h55, 8, mi);
        check("miso_first_tx", {8'd0, mi}, 16'h0011);
        ss_high();
        bus_read(3'd2, rdata);  check("toe_rx_status", rdata, 16'h01F0);
        bus_read(3'd0, rdata);  check("rxdata_55", rdata, 16'h0055);
        bus_write(3'd2, 16'h0000);

        // Partial byte discarded, following full byte received.
        ss_low();
        spi_xfer(8'hF0, 4, mi);
        ss_high();
        check("partial_no_rrdy", {15'd0, dataavailable}, 16'h0000);
        bus_read(3'd2, rdata);  check("partial_status", rdata, 16'h0060);
        ss_low();
        spi_xfer(8'hA7, 8, mi);
        ss_high();
        bus_read(3'd0, rdata);  check("rxdata_after_partial", rdata, 16'h00A7);
        bus_read(3'd5, rdata);  check("unmapped_read", rdata, 16'h0000);

        // End-of-packet register.
        bus_write(3'd6, 16'h000A);
        bus_read(3'd6, rdata);
        ss_low();
        spi_xfer(8'h0A, 8, mi);
        ss_high();
`ifdef SPI_SLAVE_EOP_EN
        check("eopval_read", rdata, 16'h000A);
        bus_read(3'd2, rdata);  check("eop_status", rdata, 16'h02E0);
        check("endofpacket", {15'd0, endofpacket}, 16'h0001);
`else
        check("eopval_absent", rdata, 16'h0000);
        bus_read(3'd2, rdata);  check("eop_status", rdata, 16'h00E0);
        check("endofpacket", {15'd0, endofpacket}, 16'h0000);
`endif
        bus_write(3'd2, 16'h0000);
        bus_read(3'd2, rdata);  check("eop_cleared", rdata, 16'h0060);
        check("endofpacket_cleared", {15'd0, endofpacket}, 16'h0000);

        // Reset asserted mid-byte.
        ss_low();
        spi_xfer(8'hFF, 3, mi);
        @(negedge clk); reset_n = 1'b0;
        #1;
        check("reset_mid_miso_oe", {15'd0, MISO_oe}, 16'h0000);
        @(negedge clk); reset_n = 1'b1; SS_n = 1'b1; SCLK = 1'b0;
        repeat (6) @(negedge clk);
        bus_read(3'd2, rdata);  check("reset_mid_status", rdata, 16'h0060);
        check("reset_mid_rrdy", {15'd0, dataavailable}, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
